// File: rtl/microwave_pkg.sv
// Shared state encodings and defaults for the microwave controller.
package microwave_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOADED = 3'd1,
        S_RUN    = 3'd2,
        S_PAUSE  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam int BEEP_TICKS_DEF = 3;

endpackage

// File: rtl/countdown_w.sv
// Remaining-time register: parallel load, saturating decrement, zero flag.
module countdown_w #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic [W-1:0] din,
    input  logic         dec,
    output logic [W-1:0] q,
    output logic         zero
);

    // Load has priority over decrement; decrement stops at zero so it never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (ld)
            q <= din;
        else if (dec && q != '0)
            q <= q - W'(1);
    end

    assign zero = (q == '0);

endmodule

// File: rtl/microwave_ctrl.sv
// Microwave oven controller: keypad/door/tick driven Moore FSM with a
// countdown for cook time and a local tick counter for the beeper.
module microwave_ctrl
    import microwave_pkg::*;
#(
    parameter int W          = 4,
    parameter int BEEP_TICKS = BEEP_TICKS_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] tin,
    input  logic         load,
    input  logic         start,
    input  logic         stop,
    input  logic         door_open,
    input  logic         tick,
    output logic         heat,
    output logic         beep,
    output logic [W-1:0] remain,
    output logic [2:0]   st
);

    localparam int BW = $clog2(BEEP_TICKS + 1);
    localparam logic [BW-1:0] BLAST = BW'(BEEP_TICKS - 1);

    state_t          state, nstate;
    logic            cd_ld, cd_dec, cd_zero;
    logic [W-1:0]    cd_din;
    logic [BW-1:0]   bcnt;
    logic            go;

    // A usable start: door shut and not overridden by a simultaneous stop.
    assign go = start && !door_open && !stop;

    countdown_w #(.W(W)) u_cd (
        .clk  (clk),
        .rst  (rst),
        .ld   (cd_ld),
        .din  (cd_din),
        .dec  (cd_dec),
        .q    (remain),
        .zero (cd_zero)
    );

    // State register; unused codes fall back to IDLE through the default arm.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= nstate;
    end

    // Beep tick counter is held at zero outside DONE, so it is 0 on entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bcnt <= '0;
        else if (state != S_DONE)
            bcnt <= '0;
        else if (tick)
            bcnt <= bcnt + BW'(1);
    end

    // Next-state and countdown control.
    always_comb begin
        nstate = state;
        cd_ld  = 1'b0;
        cd_din = '0;
        cd_dec = 1'b0;
        case (state)
            S_IDLE: begin
                if (load && tin != '0) begin
                    nstate = S_LOADED;
                    cd_ld  = 1'b1;
                    cd_din = tin;
                end
            end
            S_LOADED: begin
                if (stop) begin
                    nstate = S_IDLE;
                    cd_ld  = 1'b1;
                end else if (go) begin
                    nstate = S_RUN;
                end else if (load && tin != '0) begin
                    cd_ld  = 1'b1;
                    cd_din = tin;
                end
            end
            S_RUN: begin
                if (door_open || stop) begin
                    nstate = S_PAUSE;
                end else if (tick) begin
                    cd_dec = !cd_zero;
                    if (remain == W'(1))
                        nstate = S_DONE;
                end
            end
            S_PAUSE: begin
                if (stop) begin
                    nstate = S_IDLE;
                    cd_ld  = 1'b1;
                end else if (go) begin
                    nstate = S_RUN;
                end
            end
            S_DONE: begin
                if (stop)
                    nstate = S_IDLE;
                else if (tick && bcnt == BLAST)
                    nstate = S_IDLE;
            end
            default: nstate = S_IDLE;
        endcase
    end

    assign heat = (state == S_RUN);
    assign beep = (state == S_DONE);
    assign st   = state;

endmodule

// File: tb/tb_microwave_ctrl.sv
// Scoreboard bench: a behavioural model pushes the expected outputs after
// every rising edge; a monitor pops and compares just after that edge.
module tb_microwave_ctrl;

    localparam int W  = 4;
    localparam int BT = 3;

    // Model mode codes (display codes the controller must report).
    localparam int M_IDLE = 0, M_LOADED = 1, M_RUN = 2, M_PAUSE = 3, M_DONE = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] tin = '0;
    logic         load = 1'b0, start = 1'b0, stop = 1'b0, door_open = 1'b0, tick = 1'b0;
    logic         heat, beep;
    logic [W-1:0] remain;
    logic [2:0]   st;

    typedef struct {
        int mode;
        int rem;
    } exp_t;

    exp_t exp_q[$];
    int   m_mode = M_IDLE;
    int   m_rem  = 0;
    int   m_beeps = 0;
    int   nchk = 0;
    int   nerr = 0;
    bit   done = 1'b0;

    microwave_ctrl #(.W(W), .BEEP_TICKS(BT)) dut (
        .clk       (clk),
        .rst       (rst),
        .tin       (tin),
        .load      (load),
        .start     (start),
        .stop      (stop),
        .door_open (door_open),
        .tick      (tick),
        .heat      (heat),
        .beep      (beep),
        .remain    (remain),
        .st        (st)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int expv);
        nchk++;
        if (act != expv) begin
            nerr++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, expv);
        end
    endtask

    // Reference model: oven behaviour described directly from the keypad rules.
    always @(posedge clk) begin
        if (rst) begin
            m_mode = M_IDLE; m_rem = 0; m_beeps = 0;
        end else begin
            case (m_mode)
                M_IDLE:
                    if (load && tin != 0) begin m_mode = M_LOADED; m_rem = int'(tin); end
                M_LOADED:
                    if (stop) begin m_mode = M_IDLE; m_rem = 0; end
                    else if (start && !door_open) m_mode = M_RUN;
                    else if (load && tin != 0) m_rem = int'(tin);
                M_RUN:
                    if (door_open || stop) m_mode = M_PAUSE;
                    else if (tick) begin
                        m_rem = (m_rem > 0) ? m_rem - 1 : 0;
                        if (m_rem == 0) begin m_mode = M_DONE; m_beeps = 0; end
                    end
                M_PAUSE:
                    if (stop) begin m_mode = M_IDLE; m_rem = 0; end
                    else if (start && !door_open) m_mode = M_RUN;
                M_DONE:
                    if (stop) m_mode = M_IDLE;
                    else if (tick) begin
                        m_beeps++;
                        if (m_beeps == BT) m_mode = M_IDLE;
                    end
                default: m_mode = M_IDLE;
            endcase
        end
        exp_q.push_back('{mode: m_mode, rem: m_rem});
    end

    // Monitor: one expected record per edge, compared just after the edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!done) begin
            if (exp_q.size() == 0) begin
                chk("queue_empty", 0, 1);
            end else begin
                e = exp_q.pop_front();
                chk("st",     int'(st),     e.mode);
                chk("heat",   int'(heat),   int'(e.mode == M_RUN));
                chk("beep",   int'(beep),   int'(e.mode == M_DONE));
                chk("remain", int'(remain), e.rem);
            end
        end
    end

    // One cycle of keypad stimulus, applied on the falling edge.
    task automatic cyc(input int t, input bit l, input bit s, input bit p, input bit k);
        @(negedge clk);
        if (t >= 0) tin = W'(t);
        load = l; start = s; stop = p; tick = k;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(-1, 0, 0, 0, 0);
    endtask

    // Reset pulse between edges; outputs must clear without a clock edge.
    task automatic mid_reset();
        @(negedge clk);
        load = 0; start = 0; stop = 0; tick = 0;
        #2 rst = 1'b1;
        #1;
        chk("async_heat",   int'(heat),   0);
        chk("async_remain", int'(remain), 0);
        chk("async_st",     int'(st),     0);
        chk("async_beep",   int'(beep),   0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // Reset state is checked by the monitor while rst is held.
        idle(3);
        @(negedge clk) rst = 1'b0;

        // Full cook cycle with beeping afterwards.
        cyc(3, 1, 0, 0, 0); cyc(-1, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin idle(1); cyc(-1, 0, 0, 0, 1); end
        for (int i = 0; i < 3; i++) begin idle(1); cyc(-1, 0, 0, 0, 1); end
        idle(2);

        // Door opens together with a tick, then resume.
        cyc(5, 1, 0, 0, 0); cyc(-1, 0, 1, 0, 0);
        @(negedge clk) begin door_open = 1; tick = 1; start = 0; end
        idle(1);
        @(negedge clk) door_open = 0;
        cyc(-1, 0, 1, 0, 0); idle(1); cyc(-1, 0, 0, 0, 1); cyc(-1, 0, 0, 1, 0); cyc(-1, 0, 0, 1, 0);

        // Zero loads are ignored in LOADED and IDLE.
        cyc(4, 1, 0, 0, 0); cyc(0, 1, 0, 0, 0); cyc(-1, 0, 0, 1, 0); cyc(0, 1, 0, 0, 0);

        // Load+start together, start+stop together.
        cyc(6, 1, 0, 0, 0); cyc(9, 1, 1, 0, 0); cyc(-1, 0, 1, 1, 0); cyc(-1, 0, 1, 1, 0);

        // Stop twice from RUN.
        cyc(2, 1, 0, 0, 0); cyc(-1, 0, 1, 0, 0); cyc(-1, 0, 0, 1, 0); cyc(-1, 0, 0, 1, 0);

        // Asynchronous reset mid-RUN with remain=7.
        cyc(7, 1, 0, 0, 0); cyc(-1, 0, 1, 0, 0); idle(1);
        mid_reset();
        cyc(2, 1, 0, 0, 0); idle(1);
        cyc(-1, 0, 0, 1, 0);

        // Stop during DONE after one beep tick; also the largest load value.
        cyc(1, 1, 0, 0, 0); cyc(-1, 0, 1, 0, 0); cyc(-1, 0, 0, 0, 1);
        cyc(-1, 0, 0, 0, 1); cyc(-1, 0, 0, 1, 0); idle(1);
        cyc(15, 1, 0, 0, 0); cyc(-1, 0, 1, 0, 0); cyc(-1, 0, 0, 0, 1); cyc(-1, 0, 0, 1, 0); cyc(-1, 0, 0, 1, 0);

        // Randomised keypad, door and tick activity.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                mid_reset();
            end else begin
                @(negedge clk);
                tin   = W'($urandom_range(0, 15));
                load  = ($urandom_range(0, 99) < 10);
                start = ($urandom_range(0, 99) < 15);
                stop  = ($urandom_range(0, 99) < 4);
                tick  = ($urandom_range(0, 99) < 35);
                if ($urandom_range(0, 99) < 4) door_open = ~door_open;
            end
        end

        idle(3);
        @(negedge clk);
        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/microwave_ctrl.md
MICROWAVE_CTRL -- requirements
Module: microwave_ctrl

Interface
REQ-001 SHALL have parameter W, default 4, cook-time counter width in ticks.
REQ-002 SHALL have parameter BEEP_TICKS, default 3, number of ticks the beeper sounds in DONE.
REQ-003 SHALL have port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port tin  input  W  cook time in ticks, sampled on load.
REQ-006 SHALL have port load  input  1  one-cycle keypad pulse: load tin.
REQ-007 SHALL have port start  input  1  one-cycle keypad pulse: start or resume.
REQ-008 SHALL have port stop  input  1  one-cycle keypad pulse: pause or clear.
REQ-009 SHALL have port door_open  input  1  level, door interlock; 1 = open.
REQ-010 SHALL have port tick  input  1  one-cycle enable, 1 Hz time base.
REQ-011 SHALL have port heat  output  1  magnetron enable; 1 only in RUN.
REQ-012 SHALL have port beep  output  1  beeper; 1 only in DONE.
REQ-013 SHALL have port remain  output  W  remaining cook ticks.
REQ-014 SHALL have port st  output  3  current state encoding, for display and debug.

Function
REQ-015 SHALL implement states IDLE=0, LOADED=1, RUN=2, PAUSE=3, DONE=4; codes 5-7 SHALL return to IDLE on the next edge.
REQ-016 SHALL decode heat, beep and st from the registered state only (Moore); a command sampled at edge k is visible on outputs right after edge k.
REQ-017 IDLE: load with tin!=0 -> LOADED, remain<=tin; load with tin==0 SHALL be ignored; start/stop/tick SHALL be ignored.
REQ-018 LOADED: load with tin!=0 SHALL reload remain; stop -> IDLE with remain<=0; start with door_open=0 -> RUN; start with door_open=1 SHALL be ignored.
REQ-019 RUN: per-cycle priority door_open > stop > tick; door_open=1 or stop -> PAUSE with remain held; else tick decrements remain by 1.
REQ-020 RUN: a tick with remain==1 -> DONE and remain<=0 on the same edge; remain SHALL never wrap below 0.
REQ-021 RUN: load and start SHALL be ignored.
REQ-022 PAUSE: start with door_open=0 -> RUN; stop -> IDLE with remain<=0; tick and load SHALL be ignored.
REQ-023 DONE: the beep tick counter SHALL load 0 on entry and count ticks; on the BEEP_TICKS-th tick -> IDLE; stop -> IDLE immediately; load/start SHALL be ignored.
REQ-024 Simultaneous load and start in LOADED: start wins, and remain keeps its old value.
REQ-025 Simultaneous start and stop: stop wins in every state.

Reset
REQ-026 rst=1 SHALL force, asynchronously, state=IDLE, remain=0, beep counter=0, so heat=0, beep=0, st=0.
REQ-027 Reset asserted mid-RUN SHALL drop heat in the same cycle, without waiting for a clock edge.
REQ-028 After rst deasserts, the first load is honoured at the next rising edge.

Structure
REQ-029 State encodings and the default BEEP_TICKS SHALL live in the shared package microwave_pkg.
REQ-030 The remain register SHALL be the sub-module countdown_w: load, decrement enable, async reset, zero flag; the FSM drives it.
REQ-031 The beep tick counter SHALL be local to microwave_ctrl, width clog2(BEEP_TICKS+1).

Verification
REQ-032 tin=3, load, start, 3 ticks -> heat high for exactly 3 ticks, remain 3,2,1,0, st=DONE, beep high for 3 ticks, then IDLE.
REQ-033 RUN with remain=5, door_open=1 together with a tick -> PAUSE, remain stays 5, heat=0; door closes, start -> RUN, remain 5.
REQ-034 LOADED with tin=0, load -> remain unchanged; in IDLE, tin=0 load -> stays IDLE.
REQ-035 RUN with remain=2, stop -> PAUSE; second stop -> IDLE, remain=0.
REQ-036 rst pulse mid-RUN (remain=7) between edges -> heat=0 and remain=0 immediately; st=IDLE.
REQ-037 DONE, stop after 1 beep tick -> IDLE next edge, beep=0.
